// File: rtl/ccff_pkg.sv
// ccff_pkg: shared state encoding and count width for the configuration chain loader
package ccff_pkg;
    localparam int CNT_W = 16;
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, DONE, ERROR} state_e;
endpackage

// File: rtl/ccff_shift_stage.sv
// ccff_shift_stage: registered chain-head data and one-cycle shift strobe
module ccff_shift_stage #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         xfer_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] head_o,
    output logic         shift_en_o
);
    logic [W-1:0] head_q;
    logic         shift_en_q;
    // Capture each accepted beat and pulse the strobe for exactly one cycle; head holds between beats
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q     <= '0;
            shift_en_q <= 1'b0;
        end else begin
            shift_en_q <= xfer_i;
            if (xfer_i) head_q <= data_i;
        end
    end
    assign head_o     = head_q;
    assign shift_en_o = shift_en_q;
endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: streams bitstream beats into parallel configuration chains with framing checks
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int NUM_CHAINS    = 10,
    parameter int CHAIN_LEN     = 1024,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  prog_clock,
    input  logic                  global_resetn,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [NUM_CHAINS-1:0] s_data,
    input  logic                  s_last,
    output logic [NUM_CHAINS-1:0] ccff_head,
    output logic                  ccff_shift_en,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic                  busy,
    output logic [CNT_W-1:0]      bit_count
);
    localparam logic [CNT_W-1:0] LEN      = CNT_W'(CHAIN_LEN);
    localparam logic [7:0]       SET_LAST = 8'(SETTLE_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] bit_count_q, bit_count_d, beat;
    logic [7:0]       settle_q;
    logic             cfg_done_q, cfg_err_q, busy_q;
    logic             xfer, at_len, good_end;

    assign s_ready     = (state_q == LOAD);
    assign xfer        = s_valid & s_ready;
    assign beat        = bit_count_q + CNT_W'(1);
    assign at_len      = (beat == LEN);
    assign good_end    = at_len & s_last;
    assign bit_count_d = (bit_count_q == LEN) ? LEN : beat;

    // Load sequencer: framing is judged on the beat that carries s_last or reaches the chain length
    always_ff @(posedge prog_clock or negedge global_resetn) begin
        if (!global_resetn) begin
            state_q     <= IDLE;
            bit_count_q <= '0;
            settle_q    <= '0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: if (start) begin
                    state_q     <= LOAD;
                    bit_count_q <= '0;
                    cfg_done_q  <= 1'b0;
                    cfg_err_q   <= 1'b0;
                    busy_q      <= 1'b1;
                end
                LOAD: if (xfer) begin
                    bit_count_q <= bit_count_d;
                    if (at_len || s_last) begin
                        state_q   <= good_end ? SETTLE : ERROR;
                        cfg_err_q <= !good_end;
                        busy_q    <= good_end;
                        settle_q  <= '0;
                    end
                end
                SETTLE: if (settle_q == SET_LAST) begin
                    state_q    <= DONE;
                    cfg_done_q <= 1'b1;
                    busy_q     <= 1'b0;
                    settle_q   <= '0;
                end else begin
                    settle_q <= settle_q + 8'd1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bit_count = bit_count_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = busy_q;

    ccff_shift_stage #(.W(NUM_CHAINS)) u_shift (
        .clk_i      (prog_clock),
        .rst_ni     (global_resetn),
        .xfer_i     (xfer),
        .data_i     (s_data),
        .head_o     (ccff_head),
        .shift_en_o (ccff_shift_en)
    );
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: vector table, hand sequences and randomized loads against a transaction-level model
module tb_ccff_loader;
    localparam int NC  = 10;
    localparam int LEN = 8;
    localparam int SC  = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
    logic [NC-1:0] s_data = '0;
    logic          s_ready, shift_en, done, err, busy;
    logic [NC-1:0] head;
    logic [15:0]   bit_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [NC-1:0] shifted[$];

    ccff_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(LEN), .SETTLE_CYCLES(SC)) dut (
        .prog_clock    (clk),
        .global_resetn (rst_n),
        .start         (start),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .ccff_head     (head),
        .ccff_shift_en (shift_en),
        .cfg_done      (done),
        .cfg_err       (err),
        .busy          (busy),
        .bit_count     (bit_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && shift_en) shifted.push_back(head);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(s_ready), 0);
        chk({tag, "_head"}, 32'(head), 0);
        chk({tag, "_shift"}, 32'(shift_en), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_count"}, 32'(bit_count), 0);
    endtask

    // One load: beats 1..(term+extra) with gap idle cycles before each; s_last on beat last_pos
    task automatic run_load(input string tag, input int last_pos, input int gap, input int extra,
                            input int exp_shifts, input bit exp_done, input bit exp_err);
        logic [NC-1:0] exp_q[$];
        int nb;
        nb = exp_shifts + extra;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        shifted.delete();
        chk({tag, "_start_count"}, 32'(bit_count), 0);
        chk({tag, "_start_done"}, 32'(done), 0);
        chk({tag, "_start_err"}, 32'(err), 0);
        chk({tag, "_start_busy"}, 32'(busy), 1);
        for (int b = 1; b <= nb; b++) begin
            for (int g = 0; g < gap; g++) begin
                s_valid = 1'b0;
                @(negedge clk);
                chk({tag, "_gap_shift"}, 32'(shift_en), 0);
            end
            s_valid = 1'b1;
            s_data  = NC'($urandom);
            s_last  = (b == last_pos);
            if (b <= exp_shifts) exp_q.push_back(s_data);
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            chk({tag, "_beat_shift"}, 32'(shift_en), 32'(b <= exp_shifts));
            chk({tag, "_beat_count"}, 32'(bit_count), 32'((b <= exp_shifts) ? b : exp_shifts));
        end
        repeat (SC + 3) @(negedge clk);
        chk({tag, "_nshifts"}, 32'(shifted.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < shifted.size(); i++)
            chk({tag, "_headseq"}, 32'(shifted[i]), 32'(exp_q[i]));
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_count"}, 32'(bit_count), 32'(exp_shifts));
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ready"}, 32'(s_ready), 0);
    endtask

    typedef struct {
        string name;
        int    last_pos;
        int    gap;
        int    extra;
        int    exp_shifts;
        bit    exp_done;
        bit    exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"restart", 8, 0, 0, 8, 1'b1, 1'b0};
        vecs[1] = '{"stalled", 8, 3, 0, 8, 1'b1, 1'b0};
        vecs[2] = '{"early5",  5, 0, 3, 5, 1'b0, 1'b1};
        vecs[3] = '{"early1",  1, 1, 2, 1, 1'b0, 1'b1};
        vecs[4] = '{"missing", 0, 0, 2, 8, 1'b0, 1'b1};
        vecs[5] = '{"late9",   9, 0, 1, 8, 1'b0, 1'b1};
        vecs[6] = '{"early7",  7, 2, 0, 7, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        // Nominal cycle-exact load
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= LEN; i++) begin
            s_valid = 1'b1;
            s_data  = NC'(i);
            s_last  = (i == LEN);
            @(negedge clk);
            chk("nom_shift", 32'(shift_en), 1);
            chk("nom_head", 32'(head), 32'(i));
            chk("nom_count", 32'(bit_count), 32'(i));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int k = 1; k <= SC; k++) begin
            @(negedge clk);
            chk("nom_noshift", 32'(shift_en), 0);
            chk("nom_done_timing", 32'(done), 32'(k == SC));
            chk("nom_busy", 32'(busy), 32'(k != SC));
        end
        chk("nom_err", 32'(err), 0);
        chk("nom_head_hold", 32'(head), 32'(LEN));

        foreach (vecs[v])
            run_load(vecs[v].name, vecs[v].last_pos, vecs[v].gap, vecs[v].extra,
                     vecs[v].exp_shifts, vecs[v].exp_done, vecs[v].exp_err);

        // Reset in the middle of a load
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            s_valid = 1'b1;
            s_data  = NC'($urandom) | NC'(1);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        chk_zero("midrst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_shift", 32'(shift_en), 0);
            chk("postrst_ready", 32'(s_ready), 0);
            chk("postrst_count", 32'(bit_count), 0);
        end
        s_valid = 1'b0;
        run_load("after_rst", LEN, 0, 0, LEN, 1'b1, 1'b0);

        // Randomized loads against the framing rules
        for (int r = 0; r < 20; r++) begin
            int lp, term;
            lp   = $urandom_range(0, LEN + 1);
            term = (lp >= 1 && lp <= LEN) ? lp : LEN;
            run_load("rand", lp, $urandom_range(0, 2), $urandom_range(0, 2),
                     term, lp == LEN, lp != LEN);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
